// File: rtl/simon_pkg.sv
// Shared constants and tag type for the Simon 32/64 pipeline front end.
package simon_pkg;
  localparam int SIMON_BLOCK_W  = 32;
  localparam int SIMON_WORD_W   = 16;
  localparam int SIMON_ROUNDS   = 32;
  localparam int SIMON_PIPE_LAT = SIMON_ROUNDS + 1;
  // Sized for the largest supported requester count (8).
  localparam int ID_W = 3;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;
endpackage

// File: rtl/simon_rr_arb.sv
// Combinational round-robin: the first eligible requester after last_grant wins.
module simon_rr_arb
  import simon_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0] elig,
  input  logic [ID_W-1:0] last_grant,
  output logic [NREQ-1:0] grant,
  output logic [ID_W-1:0] grant_id,
  output logic            grant_any
);
  always_comb begin
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!grant_any && elig[i] && (i == (int'(last_grant) + k) % NREQ)) begin
          grant[i]  = 1'b1;
          grant_id  = ID_W'(i);
          grant_any = 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/simon_pipe_arbiter.sv
// Round-robin front end sharing one Simon 32/64 pipeline among NREQ requesters;
// a tag shift register matched to the pipeline latency routes results back.
module simon_pipe_arbiter
  import simon_pkg::*;
#(
  parameter int NREQ         = 2,
  parameter int PIPE_LAT     = SIMON_PIPE_LAT,
  parameter int MAX_INFLIGHT = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          key_valid,
  input  logic [NREQ-1:0]               req_valid,
  input  logic [NREQ*SIMON_BLOCK_W-1:0] req_data,
  output logic [NREQ-1:0]               req_ready,
  output logic [SIMON_BLOCK_W-1:0]      pipe_plaintext,
  input  logic [SIMON_BLOCK_W-1:0]      pipe_ciphertext,
  output logic [NREQ-1:0]               rsp_valid,
  output logic [SIMON_BLOCK_W-1:0]      rsp_data,
  output logic                          busy
);
  localparam int              CNT_W    = $clog2(MAX_INFLIGHT + 1);
  localparam logic [ID_W-1:0] LAST_RST = ID_W'(NREQ - 1);

  logic [NREQ-1:0]  elig;
  logic [NREQ-1:0]  grant;
  logic [ID_W-1:0]  grant_id;
  logic             xfer;
  logic [ID_W-1:0]  last_grant_q;
  logic [ID_W-1:0]  last_grant_d;
  tag_t             tag_q [PIPE_LAT];
  logic [CNT_W-1:0] cnt_q [NREQ];
  logic [CNT_W-1:0] cnt_d [NREQ];

  simon_rr_arb #(.NREQ(NREQ)) u_arb (
    .elig       (elig),
    .last_grant (last_grant_q),
    .grant      (grant),
    .grant_id   (grant_id),
    .grant_any  (xfer)
  );

  assign req_ready    = grant;
  assign last_grant_d = xfer ? grant_id : last_grant_q;
  assign rsp_data     = pipe_ciphertext;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
    // Eligibility is masked during reset so nothing is offered while rst is low.
    assign elig[gi] = rst & key_valid & req_valid[gi] &
                      (cnt_q[gi] < CNT_W'(MAX_INFLIGHT));
    assign rsp_valid[gi] = tag_q[PIPE_LAT-1].valid &&
                           (tag_q[PIPE_LAT-1].id == ID_W'(gi));
    assign cnt_d[gi] = (grant[gi] && !rsp_valid[gi]) ? cnt_q[gi] + CNT_W'(1) :
                       (!grant[gi] && rsp_valid[gi]) ? cnt_q[gi] - CNT_W'(1) :
                       cnt_q[gi];

    a_no_wrap: assert property (@(posedge clk) disable iff (!rst)
      !((grant[gi] && !rsp_valid[gi] && cnt_q[gi] == CNT_W'(MAX_INFLIGHT)) ||
        (!grant[gi] && rsp_valid[gi] && cnt_q[gi] == '0)));
  end

  always_comb begin
    pipe_plaintext = '0;
    for (int i = 0; i < NREQ; i++) begin
      pipe_plaintext |= {SIMON_BLOCK_W{grant[i]}} &
                        req_data[i*SIMON_BLOCK_W +: SIMON_BLOCK_W];
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int k = 0; k < PIPE_LAT; k++) begin
      busy |= tag_q[k].valid;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_q <= LAST_RST;
      for (int k = 0; k < PIPE_LAT; k++) begin
        tag_q[k] <= '0;
      end
      for (int i = 0; i < NREQ; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      last_grant_q <= last_grant_d;
      // Bubbles enter as valid=0 so each slot mirrors one pipeline stage.
      tag_q[0]     <= '{valid: xfer, id: grant_id};
      for (int k = 1; k < PIPE_LAT; k++) begin
        tag_q[k] <= tag_q[k-1];
      end
      for (int i = 0; i < NREQ; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end
endmodule

// File: tb/tb_simon_pipe_arbiter.sv
// Directed bench for simon_pipe_arbiter with a fixed-latency stand-in pipeline.
module tb_simon_pipe_arbiter;
  import simon_pkg::*;

  localparam int NREQ = 2;
  localparam int LAT  = 33;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        key_valid;
  logic [1:0]  req_valid, req_ready, rsp_valid;
  logic [63:0] req_data;
  logic [31:0] pipe_plaintext, pipe_ciphertext, rsp_data;
  logic        busy;

  logic [1:0]  b_req_valid, b_req_ready, b_rsp_valid;
  logic [63:0] b_req_data;
  logic [31:0] b_pt, b_ct, b_rsp_data;
  logic        b_busy;

  simon_pipe_arbiter #(.NREQ(NREQ), .PIPE_LAT(LAT), .MAX_INFLIGHT(8)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .pipe_plaintext(pipe_plaintext), .pipe_ciphertext(pipe_ciphertext),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy)
  );

  simon_pipe_arbiter #(.NREQ(NREQ), .PIPE_LAT(LAT), .MAX_INFLIGHT(1)) dut_b (
    .clk(clk), .rst(rst), .key_valid(key_valid),
    .req_valid(b_req_valid), .req_data(b_req_data), .req_ready(b_req_ready),
    .pipe_plaintext(b_pt), .pipe_ciphertext(b_ct),
    .rsp_valid(b_rsp_valid), .rsp_data(b_rsp_data), .busy(b_busy)
  );

  // Stand-in cipher: reference vector (key 1918_1110_0908_0100) plus a simple mix.
  function automatic logic [31:0] enc(input logic [31:0] p);
    if (p == 32'h6565_6877) return 32'hc69b_e9bb;
    return {p[15:0], p[31:16]} ^ 32'h5A5A_3C3C;
  endfunction

  logic [31:0] pa [LAT] = '{default: '0};
  logic [31:0] pb [LAT] = '{default: '0};
  always @(posedge clk) begin
    pa[0] <= enc(pipe_plaintext);
    pb[0] <= enc(b_pt);
    for (int k = 1; k < LAT; k++) begin
      pa[k] <= pa[k-1];
      pb[k] <= pb[k-1];
    end
  end
  assign pipe_ciphertext = pa[LAT-1];
  assign b_ct            = pb[LAT-1];

  typedef struct {
    int          cyc;
    int          id;
    logic [31:0] data;
  } ev_t;

  ev_t acc_log[$];
  ev_t rsp_log[$];
  int  b_acc[$];
  int  b_rsp[$];
  ev_t mon_e;
  int  cyc = 0;
  int  n_cmp = 0;
  int  n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    #2;
    if (rst) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          mon_e.cyc = cyc; mon_e.id = i; mon_e.data = req_data[i*32 +: 32];
          acc_log.push_back(mon_e);
          $display("[%0d] A accept req%0d pt=%h", cyc, i, mon_e.data);
        end
        if (rsp_valid[i]) begin
          mon_e.cyc = cyc; mon_e.id = i; mon_e.data = rsp_data;
          rsp_log.push_back(mon_e);
          $display("[%0d] A resp   req%0d ct=%h", cyc, i, rsp_data);
        end
      end
      if (b_req_valid[0] && b_req_ready[0]) begin
        b_acc.push_back(cyc);
        $display("[%0d] B accept req0 pt=%h", cyc, b_req_data[31:0]);
      end
      if (b_rsp_valid[0]) begin
        b_rsp.push_back(cyc);
        $display("[%0d] B resp   req0 ct=%h", cyc, b_rsp_data);
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy || b_busy) && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_eq(tag, {31'd0, busy | b_busy}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] c0, c1, n1;
  int          g;
  logic        exp_rdy;

  initial begin
    rst = 1'b0; key_valid = 1'b1; req_valid = 2'b11; req_data = '1;
    b_req_valid = '0; b_req_data = '0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_ready", req_ready, 0);
    check_eq("rst_rspv", rsp_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_pt", pipe_plaintext, 0);
    check_eq("rst_rsp_data", rsp_data, pa[LAT-1]);
    @(negedge clk);
    req_valid = '0; req_data = '0; rst = 1'b1;

    // Contention: strict alternation starting at requester 0
    c0 = 32'hA000_0000; c1 = 32'hB000_0000;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      req_valid = 2'b11;
      req_data  = {c1, c0};
      #1;
      g = n % 2;
      check_eq("cont_grant", req_ready, (g == 0) ? 32'd1 : 32'd2);
      check_eq("cont_pt", pipe_plaintext, (g == 0) ? c0 : c1);
      if (g == 0) c0++; else c1++;
    end
    @(negedge clk);
    req_valid = '0;
    wait_idle("cont_drain");
    check_eq("cont_rsp_cnt", rsp_log.size(), 10);
    check_eq("cont_acc_cnt", acc_log.size(), 10);
    for (int j = 0; j < 10; j++) begin
      if (j < rsp_log.size() && j < acc_log.size()) begin
        check_eq("cont_rsp_id", rsp_log[j].id, j % 2);
        check_eq("cont_rsp_data", rsp_log[j].data,
                 enc(((j % 2) == 0 ? 32'hA000_0000 : 32'hB000_0000) + 32'(j / 2)));
        check_eq("cont_latency", rsp_log[j].cyc - acc_log[j].cyc, 33);
      end
    end

    // Single block with reference vector
    acc_log.delete(); rsp_log.delete();
    @(negedge clk);
    req_valid = 2'b01; req_data = {32'h0, 32'h6565_6877};
    #1;
    check_eq("single_ready", req_ready, 1);
    check_eq("single_pt", pipe_plaintext, 32'h6565_6877);
    for (int k = 1; k <= 36; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = '0;
      #1;
      check_eq("single_busy", busy, (k <= 33) ? 32'd1 : 32'd0);
      check_eq("single_rspv", rsp_valid, (k == 33) ? 32'd1 : 32'd0);
      if (k == 33) check_eq("single_ct", rsp_data, 32'hc69b_e9bb);
    end
    check_eq("single_rsp_cnt", rsp_log.size(), 1);
    if (rsp_log.size() == 1 && acc_log.size() == 1)
      check_eq("single_latency", rsp_log[0].cyc - acc_log[0].cyc, 33);

    // Credit limit on requester 1
    n1 = 32'hC000_0000;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      req_valid = 2'b10; req_data = {n1, 32'h0};
      #1;
      exp_rdy = (k <= 7) || (k >= 34 && k <= 41);
      check_eq("credit_ready", req_ready, exp_rdy ? 32'd2 : 32'd0);
      check_eq("credit_rspv", rsp_valid, (k >= 33 && k <= 40) ? 32'd2 : 32'd0);
      if (k >= 33 && k <= 40)
        check_eq("credit_ct", rsp_data, enc(32'hC000_0000 + 32'(k - 33)));
      if (exp_rdy) n1++;
    end
    @(negedge clk);
    req_valid = '0;
    wait_idle("credit_drain");

    // Key gating
    @(negedge clk);
    key_valid = 1'b0; req_valid = 2'b11; req_data = {32'hF100_0000, 32'hF000_0000};
    for (int k = 0; k < 3; k++) begin
      #1;
      check_eq("key_ready", req_ready, 0);
      check_eq("key_busy", busy, 0);
      @(negedge clk);
    end
    key_valid = 1'b1;
    #1;
    check_eq("key_raise_ready", req_ready, 1);
    check_eq("key_raise_pt", pipe_plaintext, 32'hF000_0000);
    @(negedge clk);
    req_valid = '0;
    #1;
    check_eq("key_busy_after", busy, 1);
    wait_idle("key_drain");

    // Reset mid-flight
    acc_log.delete(); rsp_log.delete();
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      req_valid = 2'b01; req_data = {32'h0, 32'hD000_0000 + 32'(n)};
      #1;
      check_eq("rmf_ready", req_ready, 1);
    end
    @(negedge clk);
    req_valid = '0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rmf_busy_rst", busy, 0);
    check_eq("rmf_rspv_rst", rsp_valid, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    #1;
    check_eq("rmf_dropped", rsp_log.size(), 0);
    check_eq("rmf_busy_after", busy, 0);
    acc_log.delete();
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      req_valid = 2'b01; req_data = {32'h0, 32'hE000_0000 + 32'(n)};
      #1;
      check_eq("rmf_new_ready", req_ready, (n < 8) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    req_valid = '0;
    wait_idle("rmf_drain");
    check_eq("rmf_new_cnt", rsp_log.size(), 8);
    if (rsp_log.size() > 0 && acc_log.size() > 0) begin
      check_eq("rmf_new_ct", rsp_log[0].data, enc(32'hE000_0000));
      check_eq("rmf_new_latency", rsp_log[0].cyc - acc_log[0].cyc, 33);
    end

    // MAX_INFLIGHT = 1: no same-cycle bypass, reissue one cycle after the response
    for (int k = 0; k < 71; k++) begin
      @(negedge clk);
      b_req_valid = 2'b01; b_req_data = {32'h0, 32'h7000_0000 + 32'(k)};
    end
    @(negedge clk);
    b_req_valid = '0;
    wait_idle("b_drain");
    check_eq("b_acc_cnt", b_acc.size(), 3);
    if (b_acc.size() >= 3 && b_rsp.size() >= 1) begin
      check_eq("b_acc_gap1", b_acc[1] - b_acc[0], 34);
      check_eq("b_acc_gap2", b_acc[2] - b_acc[1], 34);
      check_eq("b_latency", b_rsp[0] - b_acc[0], 33);
      check_eq("b_reissue", b_acc[1] - b_rsp[0], 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
